// File: rtl/duty_ramp_pkg.sv
// duty_ramp shared types and widths.
// Used by the ramp controller and its period timer.
package duty_ramp_pkg;

  localparam int DUTY_W = 8;
  localparam int DIV_W  = 32;
  localparam int PPS_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  // Zero-valued step sizes behave as one.
  function automatic logic [DUTY_W:0] eff_step(
    input logic [DUTY_W-1:0] v
  );
    return (v == '0) ? (DUTY_W+1)'(1) : {1'b0, v};
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running PWM period counter.
// Ticks on the last count of each period.
import duty_ramp_pkg::*;

module period_timer (
  input  logic             cclk,
  input  logic             rstb,
  input  logic [DIV_W-1:0] frequency_division,
  output logic             period_tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  assign last = frequency_division - DIV_W'(1);

  // >= lets a shortened period wrap on the next edge
  assign period_tick = (frequency_division <= DIV_W'(1)) ||
                       (count >= last);

  // count 0..fd-1, wrap on tick
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (period_tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// Duty-cycle ramp controller for a PWM generator.
// Steps duty toward a target at period boundaries.
import duty_ramp_pkg::*;

module duty_ramp (
  input  logic              cclk,
  input  logic              rstb,
  input  logic [DIV_W-1:0]  frequency_division,
  input  logic [PPS_W-1:0]  periods_per_step,
  input  logic [DUTY_W-1:0] step_size,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  logic [DUTY_W-1:0] tgt, tgt_n;
  logic [DUTY_W-1:0] duty_n;
  logic [PPS_W-1:0]  step_cnt, cnt_n;
  logic              done_n;
  logic              period_tick;
  logic              accept;
  logic [PPS_W:0]    cnt_inc;
  logic [PPS_W:0]    pps_eff;
  logic [DUTY_W:0]   stp;
  logic [DUTY_W:0]   gap_up;
  logic [DUTY_W:0]   gap_dn;
  logic [DUTY_W:0]   sum_up;
  logic [DUTY_W:0]   dif_dn;

  period_timer u_timer (
    .cclk               (cclk),
    .rstb               (rstb),
    .frequency_division (frequency_division),
    .period_tick        (period_tick)
  );

  assign target_ready = (state == IDLE);
  assign busy         = (state == RAMP_UP) ||
                        (state == RAMP_DOWN);
  assign accept       = target_valid && target_ready;

  assign cnt_inc = {1'b0, step_cnt} + (PPS_W+1)'(1);
  assign pps_eff = (periods_per_step == '0) ?
                   (PPS_W+1)'(1) :
                   {1'b0, periods_per_step};
  assign stp     = eff_step(step_size);
  assign gap_up  = {1'b0, tgt} - {1'b0, duty_cycle};
  assign gap_dn  = {1'b0, duty_cycle} - {1'b0, tgt};
  assign sum_up  = {1'b0, duty_cycle} + stp;
  assign dif_dn  = {1'b0, duty_cycle} - stp;

  // state and datapath registers
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      duty_cycle <= '0;
      tgt        <= '0;
      step_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      duty_cycle <= duty_n;
      tgt        <= tgt_n;
      step_cnt   <= cnt_n;
      done       <= done_n;
    end
  end

  // accept, step pacing and saturating duty update
  always_comb begin
    state_n = state;
    duty_n  = duty_cycle;
    tgt_n   = tgt;
    cnt_n   = step_cnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          tgt_n = target_duty;
          cnt_n = '0;
          if (target_duty > duty_cycle) begin
            state_n = RAMP_UP;
          end else if (target_duty < duty_cycle) begin
            state_n = RAMP_DOWN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RAMP_UP: begin
        if (period_tick) begin
          if (cnt_inc >= pps_eff) begin
            cnt_n = '0;
            if (gap_up <= stp) begin
              duty_n  = tgt;
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              duty_n = sum_up[DUTY_W-1:0];
            end
          end else begin
            cnt_n = cnt_inc[PPS_W-1:0];
          end
        end
      end
      RAMP_DOWN: begin
        if (period_tick) begin
          if (cnt_inc >= pps_eff) begin
            cnt_n = '0;
            if (gap_dn <= stp) begin
              duty_n  = tgt;
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              duty_n = dif_dn[DUTY_W-1:0];
            end
          end else begin
            cnt_n = cnt_inc[PPS_W-1:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
